// File: rtl/snake_pkg.sv
// Shared definitions for the snake game controller and core:
// direction codes, controller state codes and the opposite-direction helper.
package snake_pkg;

    // Width of the tick counter and tick period values.
    localparam int unsigned TICK_W = 24;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    // The encoding places each direction opposite its bitwise complement.
    function automatic logic is_opposite(input dir_t a, input dir_t b);
        return (a ^ b) == 2'b11;
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Game tick divider: counts enabled cycles and pulses wrap on the last
// count of each period, then restarts from zero.
module snake_tick_gen #(
    parameter int unsigned W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] period,
    output logic         wrap
);

    logic [W-1:0] count_q;

    assign wrap = enable && (count_q == period - W'(1));

    // Counter: clear has priority, otherwise advance or wrap while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= wrap ? '0 : count_q + W'(1);
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game controller: start/pause/game-over FSM, game tick generation,
// buffered direction commits and apple scoring.
// Optional feature: define SNAKE_SPEEDUP_EN to shorten the tick period by
// STEP_DIV per apple, floored at MIN_DIV.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 1666667,
    parameter int MIN_DIV  = 416667,
    parameter int STEP_DIV = 41667
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       dir_req_valid,
    input  logic [1:0] dir_req,
    input  logic       collision,
    input  logic       apple_eaten,
    output logic       game_en,
    output logic [1:0] dir,
    output logic       core_rst,
    output logic [1:0] state,
    output logic [7:0] score
);

    localparam logic [TICK_W-1:0] TICK_PERIOD = TICK_W'(TICK_DIV);

    state_t              state_q, state_d;
    dir_t                dir_q, pend_dir_q, req_dir;
    logic                pend_valid_q;
    logic                core_rst_q;
    logic [7:0]          score_q;
    logic [TICK_W-1:0]   period_q;
    logic                start_go;
    logic                tick_en;
    logic                tick_clr;
    logic                wrap;
    logic                apple_cnt;
    logic                req_ok;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; collision outranks pause in RUN.
    always_comb begin
        state_d  = state_q;
        start_go = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (btn_start) begin
                    state_d  = ST_RUN;
                    start_go = 1'b1;
                end
            end
            ST_RUN: begin
                if (collision) begin
                    state_d = ST_OVER;
                end else if (btn_pause) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (btn_pause) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A cycle that leaves RUN is neither counted nor allowed to tick.
    assign tick_en   = (state_q == ST_RUN) && !collision && !btn_pause;
    assign tick_clr  = (state_q == ST_IDLE) || (state_q == ST_OVER);
    assign apple_cnt = (state_q == ST_RUN) && apple_eaten && !collision;

    assign req_dir = dir_t'(dir_req);
    assign req_ok  = dir_req_valid
                  && ((state_q == ST_RUN) || (state_q == ST_PAUSE))
                  && !is_opposite(req_dir, dir_q)
                  && (req_dir != dir_q);

    snake_tick_gen #(
        .W (TICK_W)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tick_clr),
        .enable (tick_en),
        .period (period_q),
        .wrap   (wrap)
    );

    // Direction: commit pending on a tick; a request in the tick cycle is
    // held for the following tick rather than committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q        <= DIR_RIGHT;
            pend_dir_q   <= DIR_RIGHT;
            pend_valid_q <= 1'b0;
        end else if (start_go) begin
            dir_q        <= DIR_RIGHT;
            pend_valid_q <= 1'b0;
        end else begin
            if (wrap && pend_valid_q) begin
                dir_q <= pend_dir_q;
            end
            if (req_ok) begin
                pend_dir_q   <= req_dir;
                pend_valid_q <= 1'b1;
            end else if (wrap) begin
                pend_valid_q <= 1'b0;
            end
        end
    end

    // Score: cleared on start, saturating apple count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q <= '0;
        end else if (start_go) begin
            score_q <= '0;
        end else if (apple_cnt && (score_q != 8'hFF)) begin
            score_q <= score_q + 8'd1;
        end
    end

    // Core reset pulse on the first cycle of a new game.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_rst_q <= 1'b0;
        end else begin
            core_rst_q <= start_go;
        end
    end

`ifdef SNAKE_SPEEDUP_EN
    localparam logic [TICK_W:0] MIN_PERIOD = (TICK_W + 1)'(MIN_DIV);
    localparam logic [TICK_W:0] STEP       = (TICK_W + 1)'(STEP_DIV);

    logic [TICK_W-1:0] target_q, target_d;

    // Apples shorten the target; the running period only adopts it at a
    // wrap so the counter never overshoots a shrunk period mid-count.
    always_comb begin
        target_d = target_q;
        if (apple_cnt) begin
            if ({1'b0, target_q} >= MIN_PERIOD + STEP) begin
                target_d = target_q - STEP[TICK_W-1:0];
            end else begin
                target_d = MIN_PERIOD[TICK_W-1:0];
            end
        end
    end

    // Target and active period registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= TICK_PERIOD;
            period_q <= TICK_PERIOD;
        end else if (start_go) begin
            target_q <= TICK_PERIOD;
            period_q <= TICK_PERIOD;
        end else begin
            target_q <= target_d;
            if (wrap) begin
                period_q <= target_d;
            end
        end
    end
`else
    assign period_q = TICK_PERIOD;
`endif

    assign game_en  = wrap;
    assign dir      = dir_q;
    assign core_rst = core_rst_q;
    assign state    = state_q;
    assign score    = score_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with TICK_DIV=4, MIN_DIV=2, STEP_DIV=1.
module tb_snake_game_ctrl;

    localparam int E_ST  = 0;
    localparam int E_DIR = 1;
    localparam int E_SC  = 2;
    localparam int E_GE  = 3;
    localparam int E_CR  = 4;
    localparam int E_GAP = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_pause = 1'b0;
    logic       dir_req_valid = 1'b0;
    logic [1:0] dir_req = 2'b00;
    logic       collision = 1'b0;
    logic       apple_eaten = 1'b0;
    logic       game_en;
    logic [1:0] dir;
    logic       core_rst;
    logic [1:0] state;
    logic [7:0] score;

    int checks = 0;
    int errors = 0;
    int last_gap = 0;

`ifdef SNAKE_SPEEDUP_EN
    int gaps[5] = '{4, 3, 2, 2, 2};
`else
    int gaps[5] = '{4, 4, 4, 4, 4};
`endif

    typedef struct {
        string tag;
        int    sel;
        int    val;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    snake_game_ctrl #(
        .TICK_DIV (4),
        .MIN_DIV  (2),
        .STEP_DIV (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_start     (btn_start),
        .btn_pause     (btn_pause),
        .dir_req_valid (dir_req_valid),
        .dir_req       (dir_req),
        .collision     (collision),
        .apple_eaten   (apple_eaten),
        .game_en       (game_en),
        .dir           (dir),
        .core_rst      (core_rst),
        .state         (state),
        .score         (score)
    );

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            E_ST:    return {30'b0, state};
            E_DIR:   return {30'b0, dir};
            E_SC:    return {24'b0, score};
            E_GE:    return {31'b0, game_en};
            E_CR:    return {31'b0, core_rst};
            default: return 32'(last_gap);
        endcase
    endfunction

    task automatic exp_(input string tag, input int sel, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk_now();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === 32'(e.val)) else begin
                errors++;
                $error("FAIL %s observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        chk_now();
        @(posedge clk);
        #1;
        btn_start     = 1'b0;
        btn_pause     = 1'b0;
        dir_req_valid = 1'b0;
        collision     = 1'b0;
        apple_eaten   = 1'b0;
    endtask

    // Counts cycles from now up to and including the next game_en.
    task automatic gap(input bit apple, input string tag, input int expv);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        exp_(tag, E_GAP, expv);
        apple_eaten = apple;
        while (!hit && n < 20) begin
            @(negedge clk);
            n++;
            hit = game_en;
            @(posedge clk);
            #1;
            apple_eaten   = 1'b0;
            dir_req_valid = 1'b0;
        end
        last_gap = hit ? n : -1;
        chk_now();
    endtask

    initial begin
        #1;
        // Reset values.
        exp_("rst_state", E_ST, 0);
        exp_("rst_dir", E_DIR, 2);
        exp_("rst_score", E_SC, 0);
        exp_("rst_game_en", E_GE, 0);
        exp_("rst_core_rst", E_CR, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Start from IDLE.
        btn_start = 1'b1;
        exp_("start_state", E_ST, 0);
        exp_("start_core_rst", E_CR, 0);
        exp_("start_game_en", E_GE, 0);
        cyc();
        for (int k = 0; k < 12; k++) begin
            if (k == 0) begin
                exp_("run_state", E_ST, 1);
                exp_("run_core_rst_hi", E_CR, 1);
                exp_("run_dir", E_DIR, 2);
                exp_("run_score", E_SC, 0);
            end
            if (k == 1) exp_("run_core_rst_lo", E_CR, 0);
            exp_("tick_period", E_GE, (k % 4 == 3) ? 1 : 0);
            cyc();
        end

        // Opposite request dropped, later request committed after the tick.
        dir_req_valid = 1'b1; dir_req = 2'b01;
        exp_("dir_hold_a", E_DIR, 2);
        cyc();
        dir_req_valid = 1'b1; dir_req = 2'b00;
        exp_("dir_hold_b", E_DIR, 2);
        cyc();
        exp_("dir_hold_c", E_DIR, 2);
        cyc();
        exp_("dir_tick_ge", E_GE, 1);
        exp_("dir_hold_d", E_DIR, 2);
        cyc();
        exp_("dir_commit_up", E_DIR, 0);
        exp_("dir_commit_ge", E_GE, 0);
        cyc();
        cyc();
        cyc();
        // Request in the tick cycle waits for the next tick.
        dir_req_valid = 1'b1; dir_req = 2'b01;
        exp_("req_on_tick_ge", E_GE, 1);
        exp_("req_on_tick_dir", E_DIR, 0);
        cyc();
        exp_("req_not_committed", E_DIR, 0);
        cyc();
        cyc();
        cyc();
        exp_("req_next_tick_ge", E_GE, 1);
        cyc();
        exp_("req_committed_left", E_DIR, 1);
        cyc();

        // Pause after two counted cycles, start ignored while paused.
        exp_("pre_pause_ge", E_GE, 0);
        cyc();
        btn_pause = 1'b1;
        exp_("pause_cycle_ge", E_GE, 0);
        exp_("pause_cycle_state", E_ST, 1);
        cyc();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) btn_start = 1'b1;
            exp_("paused_state", E_ST, 2);
            exp_("paused_ge", E_GE, 0);
            exp_("paused_core_rst", E_CR, 0);
            cyc();
        end
        btn_pause = 1'b1;
        exp_("resume_cycle_state", E_ST, 2);
        exp_("resume_cycle_ge", E_GE, 0);
        cyc();
        exp_("resumed_state", E_ST, 1);
        exp_("resumed_ge_1", E_GE, 0);
        cyc();
        exp_("resumed_ge_2", E_GE, 1);
        cyc();

        // Apple counting, then apple with collision on a would-be tick.
        apple_eaten = 1'b1;
        exp_("apple_pre_score", E_SC, 0);
        cyc();
        exp_("apple_score", E_SC, 1);
        cyc();
        cyc();
        apple_eaten = 1'b1; collision = 1'b1;
        exp_("collide_ge", E_GE, 0);
        exp_("collide_state", E_ST, 1);
        cyc();
        collision = 1'b1; apple_eaten = 1'b1;
        exp_("over_state", E_ST, 3);
        exp_("over_score", E_SC, 1);
        exp_("over_ge", E_GE, 0);
        cyc();
        btn_pause = 1'b1;
        exp_("over_hold_state", E_ST, 3);
        exp_("over_hold_score", E_SC, 1);
        cyc();
        btn_start = 1'b1;
        exp_("over_start_state", E_ST, 3);
        cyc();
        exp_("restart_state", E_ST, 1);
        exp_("restart_core_rst", E_CR, 1);
        exp_("restart_score", E_SC, 0);
        exp_("restart_dir", E_DIR, 2);
        cyc();

        // Score saturation.
        for (int i = 0; i < 300; i++) begin
            apple_eaten = 1'b1;
            if (i == 254) exp_("score_254", E_SC, 254);
            if (i == 255 || i == 299) exp_("score_sat", E_SC, 255);
            cyc();
        end
        exp_("score_final", E_SC, 255);
        exp_("sat_state", E_ST, 1);
        cyc();

        // Pause and collision together end the game.
        btn_pause = 1'b1; collision = 1'b1;
        exp_("pause_collide_ge", E_GE, 0);
        cyc();
        exp_("pause_collide_state", E_ST, 3);
        cyc();

        // Tick spacing after successive apples; start reloads the period.
        btn_start = 1'b1;
        cyc();
        gap(1'b1, "gap_1", gaps[0]);
        gap(1'b1, "gap_2", gaps[1]);
        gap(1'b1, "gap_3", gaps[2]);
        gap(1'b1, "gap_4", gaps[3]);
        dir_req_valid = 1'b1; dir_req = 2'b00;
        gap(1'b0, "gap_5", gaps[4]);

        // Asynchronous reset in the middle of a game.
        exp_("pre_rst_dir", E_DIR, 0);
        exp_("pre_rst_score", E_SC, 4);
        exp_("pre_rst_state", E_ST, 1);
        chk_now();
        #2;
        rst_n = 1'b0;
        #1;
        exp_("async_state", E_ST, 0);
        exp_("async_dir", E_DIR, 2);
        exp_("async_score", E_SC, 0);
        exp_("async_ge", E_GE, 0);
        exp_("async_core_rst", E_CR, 0);
        chk_now();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_("post_rst_state", E_ST, 0);
            exp_("post_rst_ge", E_GE, 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_game_ctrl.md
SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1666667: clk cycles per game tick, legal range 4..2^24-1.
REQ-002 SHALL have parameter MIN_DIV, default 416667: floor on the tick period when speed-up is compiled in.
REQ-003 SHALL have parameter STEP_DIV, default 41667: period decrement per apple when speed-up is compiled in.
REQ-004 SHALL provide ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- btn_start  in  1  one-cycle start/restart pulse.
- btn_pause  in  1  one-cycle pause-toggle pulse.
- dir_req_valid  in  1  direction request strobe.
- dir_req  in  2  requested direction.
- collision  in  1  one-cycle pulse from core.
- apple_eaten  in  1  one-cycle pulse from core.
- game_en  out  1  one-cycle game tick to core.
- dir  out  2  committed direction to core.
- core_rst  out  1  one-cycle synchronous, active-high reset to core.
- state  out  2  FSM state.
- score  out  8  apple count.

Function
REQ-005 Direction encoding SHALL be: 00 up, 01 left, 10 right, 11 down; two directions are opposite iff a XOR b == 11.
REQ-006 FSM SHALL have states IDLE=00, RUN=01, PAUSE=10, OVER=11; state output SHALL equal the current state register.
REQ-007 IDLE or OVER with btn_start SHALL transition to RUN next cycle, with core_rst=1 for exactly that transition cycle, score cleared to 0, dir set to 10, pending direction invalidated and tick counter cleared.
REQ-008 RUN with btn_pause SHALL go to PAUSE; PAUSE with btn_pause SHALL go to RUN; btn_start SHALL be ignored in RUN and PAUSE.
REQ-009 RUN with collision SHALL go to OVER; collision SHALL be ignored outside RUN.
REQ-010 Tick counter SHALL increment only in RUN, hold in PAUSE and clear in IDLE/OVER; when it equals period-1 in RUN, game_en SHALL be 1 for that cycle and the counter SHALL wrap to 0.
REQ-011 game_en SHALL be 0 in any cycle where collision or btn_pause is asserted, and in every cycle outside RUN.
REQ-012 dir_req_valid in RUN or PAUSE SHALL latch dir_req into a single pending register, latest request wins, unless dir_req is opposite to or equal to the committed dir, in which case the request SHALL be dropped.
REQ-013 On a game_en cycle, a valid pending direction SHALL become dir on the following cycle and pending SHALL invalidate; dir SHALL change at most once per tick.
REQ-014 A request arriving in the same cycle as game_en SHALL be latched as pending for the next tick, not committed.
REQ-015 apple_eaten in RUN SHALL increment score, saturating at 255; if collision is asserted in the same cycle, collision SHALL win and score SHALL NOT increment.
REQ-016 Simultaneous btn_pause and collision in RUN SHALL go to OVER.

Reset
REQ-017 While rst_n=0, asynchronously: state=IDLE, game_en=0, core_rst=0, dir=10, score=0, counter=0, pending invalid, period=TICK_DIV.
REQ-018 Reset deassertion mid-game SHALL leave the block in IDLE awaiting btn_start; no game_en SHALL occur before the first start.

Configuration
REQ-019 With SNAKE_SPEEDUP_EN defined, each counted apple SHALL reduce the period by STEP_DIV, floored at MIN_DIV; the new period SHALL take effect from the next counter wrap; start SHALL reload TICK_DIV.
REQ-020 Without SNAKE_SPEEDUP_EN, period SHALL be constantly TICK_DIV and MIN_DIV/STEP_DIV SHALL be unused.

Structure
REQ-021 Direction codes, state codes and an is_opposite helper SHALL live in shared package snake_pkg, used also by snake_core.
REQ-022 Tick counter with period input, enable, clear and wrap pulse SHALL be sub-module snake_tick_gen.

Verification (TICK_DIV=4, MIN_DIV=2, STEP_DIV=1)
REQ-023 Reset, btn_start -> core_rst pulse, state=01, game_en every 4th cycle, dir=10.
REQ-024 dir=10, request 01 then 00 before tick -> 01 dropped; dir=00 the cycle after next game_en.
REQ-025 btn_pause after 2 counted cycles, wait 10, btn_pause -> no game_en while paused; next game_en 2 cycles after resume.
REQ-026 apple_eaten and collision in the same cycle -> state=11, score unchanged, game_en=0; btn_start -> score=0, state=01.
REQ-027 300 apple pulses -> score=255; with SNAKE_SPEEDUP_EN, tick spacing 4,3,2,2 after successive apples.
REQ-028 rst_n low mid-RUN -> all outputs at reset values immediately, without waiting for clk.
